// File: rtl/axi_defs_pkg.sv
// rtl/axi_defs_pkg.sv - shared constants and FSM encodings for the AXI SRAM responder
// Purpose: response and burst codes, read/write FSM state types, and the
//          stall LFSR seed and feedback taps.
// Ports:   none (package)
package axi_defs_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_LAT  = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (maximal length).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/axi_stall_lfsr.sv
// rtl/axi_stall_lfsr.sv - pseudo-random stall mask for master back-pressure testing
// Purpose: 16-bit LFSR stepped every cycle; its low five bits form a stall
//          mask. Only built when AXI_SLAVE_STALL_EN is defined.
// Ports:   clk   - clock
//          rst   - async active-high reset (reloads the seed)
//          stall - [0] arready, [1] awready, [2] wready, [3] rvalid, [4] bvalid
`ifdef AXI_SLAVE_STALL_EN
module axi_stall_lfsr
  import axi_defs_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [4:0] stall
);

  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign stall = lfsr[4:0];

endmodule
`endif

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 responder backed by a word-addressed on-chip memory
// Purpose: one outstanding read and one outstanding write burst (INCR/FIXED,
//          up to 16 beats), OKAY responses, configurable read latency.
// Params:  MEM_AW - word-address width (2^MEM_AW 32-bit words)
//          RD_LAT - cycles from AR acceptance to first rvalid (1..15)
// Macro:   AXI_SLAVE_STALL_EN - gate the ready/valid outputs with an LFSR
// Ports:   clk, rst (async active-high)
//          AR: arid, araddr, arlen, arsize, arburst, arvalid -> arready
//          R : rid, rdata, rresp, rlast, rvalid <- rready
//          AW: awid, awaddr, awlen, awsize, awburst, awvalid -> awready
//          W : wid, wdata, wstrb, wlast, wvalid -> wready
//          B : bid, bresp, bvalid <- bready
module axi_sram_slave
  import axi_defs_pkg::*;
#(
  parameter int MEM_AW = 16,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  // Byte-address width kept internally; bits above it alias away.
  localparam int AB = MEM_AW + 2;

  function automatic logic [AB-1:0] step_addr(input logic [AB-1:0] a,
                                              input logic [2:0]    size,
                                              input logic [1:0]    burst);
    // WRAP is deliberately handled like INCR.
    if (burst == BURST_FIXED) return a;
    return a + AB'(32'd1 << size);
  endfunction

  logic [31:0] mem [2**MEM_AW];

  logic [4:0] stall;
`ifdef AXI_SLAVE_STALL_EN
  axi_stall_lfsr u_stall_lfsr (
    .clk   (clk),
    .rst   (rst),
    .stall (stall)
  );
`else
  assign stall = 5'b00000;
`endif

  // wid and the unused address/length bits are intentionally ignored.
  logic unused_in;
  assign unused_in = ^{araddr, awaddr, arlen[7:4], wid};

  // ---------------- read channel ----------------
  rd_state_t     r_state, r_next;
  logic [AB-1:0] r_addr;
  logic [3:0]    r_beats;
  logic [3:0]    r_cnt;
  logic [3:0]    r_id;
  logic [2:0]    r_size;
  logic [1:0]    r_burst;
  logic          ar_hs, r_hs;

  // rst is folded into the readies so they stay low while reset is held.
  assign arready = (r_state == R_IDLE) && !rst && !stall[0];
  assign rvalid  = (r_state == R_DATA) && !stall[3];
  assign rlast   = (r_state == R_DATA) && (r_beats == 4'd0);
  // Asynchronous array read: a same-cycle write is visible only after the edge.
  assign rdata   = (r_state == R_DATA) ? mem[r_addr[AB-1:2]] : 32'h0;
  assign rid     = r_id;
  assign rresp   = RESP_OKAY;

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: if (ar_hs) r_next = (RD_LAT == 1) ? R_DATA : R_LAT;
      // r_cnt holds the cycles still to wait; leave when the last one expires.
      R_LAT:  if (r_cnt == 4'd1) r_next = R_DATA;
      R_DATA: if (r_hs && (r_beats == 4'd0)) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_beats <= 4'd0;
      r_cnt   <= 4'd0;
      r_id    <= 4'd0;
      r_size  <= 3'd0;
      r_burst <= 2'd0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        r_id    <= arid;
        r_addr  <= araddr[AB-1:0];
        r_beats <= arlen[3:0];
        r_size  <= arsize;
        r_burst <= arburst;
        r_cnt   <= 4'(RD_LAT - 1);
      end else if (r_state == R_LAT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_hs) begin
        r_addr  <= step_addr(r_addr, r_size, r_burst);
        r_beats <= r_beats - 4'd1;
      end
    end
  end

  // ---------------- write channel ----------------
  wr_state_t     w_state, w_next;
  logic [AB-1:0] w_addr;
  logic [3:0]    w_beats;
  logic [3:0]    w_id;
  logic [2:0]    w_size;
  logic [1:0]    w_burst;
  logic          aw_hs, w_hs, w_done;

  assign awready = (w_state == W_IDLE) && !rst && !stall[1];
  assign wready  = (w_state == W_DATA) && !stall[2];
  assign bvalid  = (w_state == W_RESP) && !stall[4];
  assign bid     = w_id;
  assign bresp   = RESP_OKAY;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  // An early wlast or an over-long burst both close the burst.
  assign w_done = w_hs && (wlast || (w_beats == 4'd0));

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (aw_hs) w_next = W_DATA;
      W_DATA: if (w_done) w_next = W_RESP;
      W_RESP: if (bvalid && bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_beats <= 4'd0;
      w_id    <= 4'd0;
      w_size  <= 3'd0;
      w_burst <= 2'd0;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        w_id    <= awid;
        w_addr  <= awaddr[AB-1:0];
        w_beats <= awlen;
        w_size  <= awsize;
        w_burst <= awburst;
      end
      if (w_hs) begin
        w_addr  <= step_addr(w_addr, w_size, w_burst);
        w_beats <= w_beats - 4'd1;
      end
    end
  end

  // Memory contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[w_addr[AB-1:2]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - self-checking bench for axi_sram_slave
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        ar_go, sel;
  logic        arvalid, s_arvalid;
  logic        arready, s_arready;
  logic [3:0]  rid, s_rid;
  logic [31:0] rdata, s_rdata;
  logic [1:0]  rresp, s_rresp;
  logic        rlast, s_rlast, rvalid, s_rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready, s_awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready, s_wready;
  logic [3:0]  bid, s_bid;
  logic [1:0]  bresp, s_bresp;
  logic        bvalid, s_bvalid, bready;

  int checks = 0;
  int errors = 0;

  logic [31:0] wbuf [16];
  logic [31:0] rbuf [16];

  always #5 clk = ~clk;

  assign arvalid   = ar_go && !sel;
  assign s_arvalid = ar_go && sel;

  // Main instance: large memory, 3-cycle read latency.
  axi_sram_slave #(.MEM_AW(16), .RD_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Small instance: 16 words, 1-cycle latency; shares the write stimulus.
  axi_sram_slave #(.MEM_AW(4), .RD_LAT(1)) dut_s (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(s_arvalid), .arready(s_arready),
    .rid(s_rid), .rdata(s_rdata), .rresp(s_rresp), .rlast(s_rlast), .rvalid(s_rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(s_awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(s_wready),
    .bid(s_bid), .bresp(s_bresp), .bvalid(s_bvalid), .bready(bready)
  );

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdat;
    logic [3:0]  strb;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [3:0] len,
                             input logic [3:0] id, input logic [3:0] strb);
    int n;
    awaddr = addr; awlen = len; awid = id; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin tick(); n++; end
    check("awready", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wdata = wbuf[b]; wstrb = strb; wid = id; wlast = (b == int'(len)); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 20) begin tick(); n++; end
      if (!wready) check("wready_timeout", 32'(wready), 32'd1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("bvalid_after_wlast", 32'(bvalid), 32'd1);
    check("bid", 32'(bid), 32'(id));
    check("bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bvalid_cleared", 32'(bvalid), 32'd0);
  endtask

  task automatic read_burst(input logic s, input logic [31:0] addr, input logic [3:0] len,
                            input logic [3:0] id, input logic toggle);
    int n, lat, k, cyc;
    logic held;
    logic c_arready, c_rvalid, c_rlast;
    logic [31:0] c_rdata;
    logic [3:0] c_rid;
    logic [1:0] c_rresp;
    sel = s; araddr = addr; arlen = {4'd0, len}; arid = id; arsize = 3'd2; arburst = 2'b01;
    ar_go = 1'b1;
    #1;
    n = 0;
    c_arready = s ? s_arready : arready;
    while (!c_arready && n < 20) begin tick(); n++; c_arready = s ? s_arready : arready; end
    check("arready", 32'(c_arready), 32'd1);
    tick();
    ar_go = 1'b0;
    lat = 1;
    c_rvalid = s ? s_rvalid : rvalid;
    while (!c_rvalid && lat < 20) begin tick(); lat++; c_rvalid = s ? s_rvalid : rvalid; end
    check("rd_latency", 32'(lat), s ? 32'd1 : 32'd3);
    k = 0; cyc = 0; held = 1'b0;
    while (k <= int'(len) && cyc < 100) begin
      rready   = toggle ? ((cyc % 2) == 0) : 1'b1;
      c_rvalid = s ? s_rvalid : rvalid;
      c_rdata  = s ? s_rdata : rdata;
      c_rlast  = s ? s_rlast : rlast;
      c_rid    = s ? s_rid : rid;
      c_rresp  = s ? s_rresp : rresp;
      check("rvalid_beat", 32'(c_rvalid), 32'd1);
      if (held) check("rdata_held", c_rdata, rbuf[k]);
      rbuf[k] = c_rdata;
      check("rlast", 32'(c_rlast), 32'(k == int'(len)));
      check("rid", 32'(c_rid), 32'(id));
      check("rresp", 32'(c_rresp), 32'd0);
      tick();
      held = !rready;
      if (rready) k++;
      cyc++;
    end
    rready = 1'b0;
    c_rvalid = s ? s_rvalid : rvalid;
    check("rvalid_after_burst", 32'(c_rvalid), 32'd0);
  endtask

  initial begin
    int n;
    logic seen;
    vecs[0] = '{32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0000_0020, 32'h1122_3344};
    vecs[2] = '{32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0000_0020, 32'h11BB_33DD};
    vecs[3] = '{32'h0000_0024, 32'h5566_7788, 4'hF, 32'h0000_0024, 32'h5566_7788};
    vecs[4] = '{32'h0000_0024, 32'h0000_0000, 4'hA, 32'h0000_0024, 32'h0066_0088};
    vecs[5] = '{32'h0004_0020, 32'hCAFE_F00D, 4'hF, 32'h0000_0020, 32'hCAFE_F00D};
    vecs[6] = '{32'h0000_0020, 32'h9900_0000, 4'h8, 32'h0004_0020, 32'h99FE_F00D};

    rst = 1'b1; ar_go = 1'b0; sel = 1'b0; rready = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;

    // Reset state.
    tick(); tick();
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_rid", 32'(rid), 32'd0);
    check("rst_bid", 32'(bid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_resp", 32'({rresp, bresp}), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_arready", 32'(arready), 32'd1);
    check("post_rst_awready", 32'(awready), 32'd1);

    // Table: single-beat write, then single-beat read-back.
    for (int i = 0; i < 7; i++) begin
      wbuf[0] = vecs[i].wdat;
      write_burst(vecs[i].waddr, 4'd0, 4'(i), vecs[i].strb);
      read_burst(1'b0, vecs[i].raddr, 4'd0, 4'(i + 8), 1'b0);
      check($sformatf("vec%0d_rdata", i), rbuf[0], vecs[i].exp);
    end

    // 4-beat INCR read with rready toggling 1,0,1,0.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA000_0040 + 32'(4 * i);
    write_burst(32'h40, 4'd3, 4'd2, 4'hF);
    read_burst(1'b0, 32'h40, 4'd3, 4'd9, 1'b1);
    for (int i = 0; i < 4; i++)
      check($sformatf("incr4_beat%0d", i), rbuf[i], 32'hA000_0040 + 32'(4 * i));

    // Same-cycle read and write of word 0x80.
    wbuf[0] = 32'h1;
    write_burst(32'h80, 4'd0, 4'd1, 4'hF);
    sel = 1'b0; araddr = 32'h80; arlen = 8'd0; arid = 4'd3; arsize = 3'd2; arburst = 2'b01;
    awaddr = 32'h80; awlen = 4'd0; awid = 4'd4; awsize = 3'd2; awburst = 2'b01;
    ar_go = 1'b1; awvalid = 1'b1;
    #1;
    check("rw_ar_aw_ready", 32'({arready, awready}), 32'd3);
    tick();
    ar_go = 1'b0; awvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    wdata = 32'h2; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1; rready = 1'b1;
    check("rw_rvalid", 32'(rvalid), 32'd1);
    check("rw_wready", 32'(wready), 32'd1);
    check("rw_old_data", rdata, 32'h1);
    tick();
    wvalid = 1'b0; wlast = 1'b0; rready = 1'b0;
    check("rw_bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    read_burst(1'b0, 32'h80, 4'd0, 4'd5, 1'b0);
    check("rw_new_data", rbuf[0], 32'h2);

    // Word-index wrap on the 16-word instance.
    wbuf[0] = 32'h1111_AAAA; wbuf[1] = 32'h2222_BBBB;
    write_burst(32'h3C, 4'd1, 4'd6, 4'hF);
    read_burst(1'b1, 32'h00, 4'd0, 4'd7, 1'b0);
    check("wrap_word0", rbuf[0], 32'h2222_BBBB);
    read_burst(1'b1, 32'h3C, 4'd1, 4'd8, 1'b0);
    check("wrap_rd_beat0", rbuf[0], 32'h1111_AAAA);
    check("wrap_rd_beat1", rbuf[1], 32'h2222_BBBB);

    // Reset during the 3rd beat of an 8-beat read.
    sel = 1'b0; araddr = 32'h40; arlen = 8'd7; arid = 4'hC; ar_go = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    tick();
    ar_go = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    rready = 1'b1;
    tick(); tick();
    check("abort_3rd_beat_valid", 32'(rvalid), 32'd1);
    check("abort_3rd_beat_data", rdata, 32'hA000_0048);
    rst = 1'b1;
    tick();
    check("abort_rvalid", 32'(rvalid), 32'd0);
    check("abort_arready", 32'(arready), 32'd0);
    check("abort_rid", 32'(rid), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    rst = 1'b0;
    tick();
    check("abort_arready_back", 32'(arready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (rvalid || bvalid) seen = 1'b1;
      tick();
    end
    rready = 1'b0;
    check("abort_no_more_beats", 32'(seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
